// File: rtl/act_stream_feeder_pkg.sv
// Shared constants and state encoding for the Q8.8 activation feeder and its
// downstream activation units.
package act_pkg;
    localparam int DATA_WIDTH        = 16;
    localparam int FRACTION_BITS     = 8;
    localparam int ADDR_WIDTH        = 8;
    localparam int BUF_DEPTH         = 201;
    localparam int HSIGMOID_LATENCY  = 3;
    localparam int HSWISH_LATENCY    = 3;
    localparam int FEED_PIPE_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } feeder_state_e;
endpackage

// File: rtl/act_stream_feeder_if.sv
// Load/stream bus between the feeder and its host or activation unit.
interface act_stream_feeder_if;
    import act_pkg::*;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  clear;
    logic                  go;
    logic                  hold;
    logic [DATA_WIDTH-1:0] x;
    logic                  start;
    logic                  end_flag;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] fill_count;
    logic                  full;
    logic                  wr_err;

    modport master (
        output wr_en, wr_data, clear, go, hold,
        input  x, start, end_flag, busy, fill_count, full, wr_err
    );

    modport slave (
        input  wr_en, wr_data, clear, go, hold,
        output x, start, end_flag, busy, fill_count, full, wr_err
    );
endinterface

// File: rtl/act_stream_feeder_sample_buf.sv
// Frame buffer: synchronous write, registered read; the array itself is never
// reset, only the read register.
module sample_buf
    import act_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register; holds its value whenever no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end
endmodule

// File: rtl/act_stream_feeder.sv
// Activation stream feeder: buffers a frame of Q8.8 samples, streams it one per
// cycle on go, waits for the activation pipeline to drain, then pulses end_flag.
module act_stream_feeder
    import act_pkg::*;
#(
    parameter int DEPTH        = BUF_DEPTH,
    parameter int PIPE_LATENCY = FEED_PIPE_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    act_stream_feeder_if.slave  bus
);
    localparam logic [3:0] DRAIN_LOAD = 4'(PIPE_LATENCY + 1);

    feeder_state_e         state_r;
    logic [ADDR_WIDTH-1:0] fill_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [3:0]            drain_cnt_r;
    logic                  start_r;
    logic                  end_flag_r;
    logic                  busy_r;
    logic                  full_r;
    logic                  wr_err_r;
    logic [DATA_WIDTH-1:0] x_s;

    logic                  idle_s;
    logic                  wr_ok_s;
    logic                  rd_en_s;
    logic                  last_s;
    logic [ADDR_WIDTH-1:0] fill_next_s;

    // Write acceptance and next fill level; clear beats a same-cycle write.
    always_comb begin
        idle_s      = (state_r == IDLE);
        wr_ok_s     = idle_s && bus.wr_en && !bus.clear && !full_r;
        rd_en_s     = (state_r == STREAM) && !bus.hold;
        last_s      = (rd_ptr_r == (fill_r - ADDR_WIDTH'(1)));
        fill_next_s = fill_r;
        if (!idle_s) begin
            fill_next_s = fill_r;
        end else if (bus.clear) begin
            fill_next_s = {ADDR_WIDTH{1'b0}};
        end else if (wr_ok_s) begin
            fill_next_s = fill_r + ADDR_WIDTH'(1);
        end else begin
            fill_next_s = fill_r;
        end
    end

    sample_buf #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok_s),
        .waddr (fill_r),
        .wdata (bus.wr_data),
        .re    (rd_en_s),
        .raddr (rd_ptr_r),
        .rdata (x_s)
    );

    // Fill bookkeeping, sticky write error and the frame sequencing FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            fill_r      <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
            drain_cnt_r <= 4'd0;
            start_r     <= 1'b0;
            end_flag_r  <= 1'b0;
            busy_r      <= 1'b0;
            full_r      <= 1'b0;
            wr_err_r    <= 1'b0;
        end else begin
            fill_r <= fill_next_s;
            full_r <= (fill_next_s == ADDR_WIDTH'(DEPTH));

            if (!idle_s) begin
                if (bus.wr_en) begin
                    wr_err_r <= 1'b1;
                end
            end else if (bus.clear) begin
                wr_err_r <= 1'b0;
            end else if (bus.wr_en && full_r) begin
                wr_err_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    start_r    <= 1'b0;
                    end_flag_r <= 1'b0;
                    if (bus.go && (fill_next_s != {ADDR_WIDTH{1'b0}})) begin
                        rd_ptr_r <= {ADDR_WIDTH{1'b0}};
                        state_r  <= STREAM;
                        busy_r   <= 1'b1;
                    end else if (bus.go) begin
                        state_r    <= FINISH;
                        end_flag_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                STREAM: begin
                    if (!bus.hold) begin
                        start_r  <= 1'b1;
                        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
                        if (last_s) begin
                            state_r     <= DRAIN;
                            drain_cnt_r <= DRAIN_LOAD;
                        end
                    end else begin
                        start_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    start_r <= 1'b0;
                    if (drain_cnt_r == 4'd0) begin
                        state_r    <= FINISH;
                        end_flag_r <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 4'd1;
                    end
                end
                FINISH: begin
                    end_flag_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    start_r    <= 1'b0;
                    end_flag_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.x          = x_s;
    assign bus.start      = start_r;
    assign bus.end_flag   = end_flag_r;
    assign bus.busy       = busy_r;
    assign bus.fill_count = fill_r;
    assign bus.full       = full_r;
    assign bus.wr_err     = wr_err_r;
endmodule
